// File: rtl/sobel_frame_ctrl_if.sv
// Handshake and address bundle between a frame host and sobel_frame_ctrl.
// master: the host that requests frames and applies back-pressure.
// slave: the frame sequencer itself.
interface sobel_frame_ctrl_if #(
  parameter int AW = 16,
  parameter int OW = 16
);
  logic          start;
  logic          stall;
  logic          ce;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          pix_valid;
  logic          win_valid;
  logic          wr_en;
  logic [OW-1:0] wr_addr;
  logic [31:0]   total_cycles;

  modport master (
    output start, stall,
    input  ce, busy, done, rd_en, rd_addr, pix_valid, win_valid,
           wr_en, wr_addr, total_cycles
  );

  modport slave (
    input  start, stall,
    output ce, busy, done, rd_en, rd_addr, pix_valid, win_valid,
           wr_en, wr_addr, total_cycles
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel edge-detection datapath.
// Walks the input image in raster order, tags pixels that complete a 3x3
// window, aligns output write strobes to the datapath latency, drains the
// pipeline and reports done.
// Optional feature macro: SOBEL_CTRL_CYCLE_CNT_EN builds the 32-bit
// total_cycles counter; without it total_cycles is tied to 0.
module sobel_frame_ctrl #(
  parameter int WIDTH    = 240,
  parameter int HEIGHT   = 240,
  parameter int RD_LAT   = 1,
  parameter int PIPE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  sobel_frame_ctrl_if.slave  bus
);

  localparam int TOTAL  = WIDTH * HEIGHT;
  localparam int OUTTOT = (WIDTH - 2) * (HEIGHT - 2);
  localparam int AW     = $clog2(TOTAL);
  localparam int OW     = (OUTTOT > 1) ? $clog2(OUTTOT) : 1;
  localparam int CW     = $clog2(WIDTH);
  localparam int RW     = $clog2(HEIGHT);
  localparam int DLAT   = RD_LAT + PIPE_LAT;
  localparam int DW     = $clog2(DLAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [AW-1:0]       rd_addr_q, rd_addr_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [OW-1:0]       wr_addr_q, wr_addr_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic [RD_LAT-1:0]   pv_q, pv_d;     // read-valid delay line
  logic [RD_LAT-1:0]   el_q, el_d;     // window-eligible tag travelling with each read
  logic [PIPE_LAT-1:0] wv_q, wv_d;     // window-valid delay line towards the write strobe

  logic ce;
  logic rd_en;
  logic elig;
  logic pix_stage;
  logic win_stage;
  logic wr_stage;
  logic start_ok;

  // Strobes respond to stall in the same cycle; delay-line contents are frozen by ce.
  assign ce        = busy_q & ~bus.stall;
  assign rd_en     = (state_q == S_FETCH) & ~bus.stall;
  assign elig      = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign pix_stage = pv_q[RD_LAT-1];
  assign win_stage = pix_stage & el_q[RD_LAT-1];
  assign wr_stage  = wv_q[PIPE_LAT-1];
  assign start_ok  = bus.start & ((state_q == S_IDLE) | (state_q == S_DONE));

  assign bus.ce        = ce;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.pix_valid = pix_stage & ce;
  assign bus.win_valid = win_stage & ce;
  assign bus.wr_en     = wr_stage & ce;
  assign bus.wr_addr   = wr_addr_q;

  // Next-state: sequencing, raster position, delay lines and write address.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the
    // case/if tree leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    rd_addr_d = rd_addr_q;
    col_d     = col_q;
    row_d     = row_q;
    wr_addr_d = wr_addr_q;
    drain_d   = drain_q;
    pv_d      = pv_q;
    el_d      = el_q;
    wv_d      = wv_q;

    if (ce) begin
      pv_d[0] = rd_en;
      el_d[0] = elig;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_d[i] = pv_q[i-1];
        el_d[i] = el_q[i-1];
      end
      wv_d[0] = win_stage;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wv_d[i] = wv_q[i-1];
      end
    end

    // Output address saturates at the last window so it cannot wrap in a frame.
    if (wr_stage && ce && (wr_addr_q != OW'(OUTTOT - 1))) begin
      wr_addr_d = wr_addr_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_FETCH;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          rd_addr_d = '0;
          col_d     = '0;
          row_d     = '0;
          wr_addr_d = '0;
          drain_d   = '0;
          pv_d      = '0;
          el_d      = '0;
          wv_d      = '0;
        end
      end
      S_FETCH: begin
        if (rd_en) begin
          if (rd_addr_q == AW'(TOTAL - 1)) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            if (col_q == CW'(WIDTH - 1)) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (ce) begin
          if (drain_q == DW'(DLAT - 1)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; async reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_addr_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      wr_addr_q <= '0;
      drain_q   <= '0;
      pv_q      <= '0;
      el_q      <= '0;
      wv_q      <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_addr_q <= rd_addr_d;
      col_q     <= col_d;
      row_q     <= row_d;
      wr_addr_q <= wr_addr_d;
      drain_q   <= drain_d;
      pv_q      <= pv_d;
      el_q      <= el_d;
      wv_q      <= wv_d;
    end
  end

`ifdef SOBEL_CTRL_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  // Frame cycle counter: cleared on an accepted start, saturating while busy.
  always_comb begin
    cyc_d = cyc_q;
    if (start_ok) begin
      cyc_d = '0;
    end else if (busy_q && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign bus.total_cycles = cyc_q;
`else
  logic unused_start_ok;
  assign unused_start_ok  = start_ok;
  assign bus.total_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl (5x4 image, RD_LAT=1, PIPE_LAT=2).
// Expected read, pixel, window and write events are pushed to queues from a
// cycle model when a frame is launched and popped as the DUT produces them.
module tb_sobel_frame_ctrl;

  localparam int W      = 5;
  localparam int H      = 4;
  localparam int RDL    = 1;
  localparam int PL     = 2;
  localparam int TOT    = W * H;
  localparam int STEPS  = TOT + RDL + PL;
  localparam int AW_T   = $clog2(TOT);
  localparam int OW_T   = $clog2((W - 2) * (H - 2));
  localparam int LIMIT  = 400;

  typedef struct {
    int addr;
    int cyc;
  } ev_t;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  ev_t rd_q[$];
  ev_t pix_q[$];
  ev_t win_q[$];
  ev_t wr_q[$];

  sobel_frame_ctrl_if #(.AW(AW_T), .OW(OW_T)) bus ();

  sobel_frame_ctrl #(
    .WIDTH   (W),
    .HEIGHT  (H),
    .RD_LAT  (RDL),
    .PIPE_LAT(PL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_total(input int cyc);
`ifdef SOBEL_CTRL_CYCLE_CNT_EN
    return cyc;
`else
    return 0;
`endif
  endfunction

  // Runs one frame. Cycle 0 is the first FETCH cycle. st0/st_len: stall
  // window; re_cyc: cycle of a spurious start; rs_cyc: cycle of a reset;
  // b2b: issue the next start in the first DONE cycle.
  task automatic frame(input bit do_start, input int st0, input int st_len,
                       input int re_cyc, input int rs_cyc, input bit b2b,
                       input string tag);
    int  act[$];
    int  c;
    int  k;
    int  done_cyc;
    bit  finished;
    bit  stl;
    bit  exp_ce;
    ev_t e;

    // Model: step n of the frame happens on the n-th non-stalled cycle.
    c = 0;
    while (act.size() < STEPS) begin
      if (!(c >= st0 && c < st0 + st_len)) act.push_back(c);
      c++;
    end
    done_cyc = act[STEPS-1] + 1;
    rd_q.delete(); pix_q.delete(); win_q.delete(); wr_q.delete();
    k = 0;
    for (int a = 0; a < TOT; a++) begin
      rd_q.push_back('{a, act[a]});
      pix_q.push_back('{a, act[a+RDL]});
      if ((a / W) >= 2 && (a % W) >= 2) begin
        win_q.push_back('{a, act[a+RDL]});
        wr_q.push_back('{k, act[a+RDL+PL]});
        k++;
      end
    end

    if (do_start) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.stall = 1'b0;
    end

    finished = 1'b0;
    for (int cy = 0; cy < LIMIT; cy++) begin
      @(negedge clk);
      bus.start = (cy == re_cyc);
      stl       = (cy >= st0 && cy < st0 + st_len);
      bus.stall = stl;
      #1;

      if (cy == rs_cyc) begin
        bus.start = 1'b0;
        bus.stall = 1'b0;
        rst_n     = 1'b0;
        #1;
        checks++;
        if ({bus.ce, bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.pix_valid,
             bus.win_valid, bus.wr_en, bus.wr_addr, bus.total_cycles} !== '0) begin
          errors++;
          $display("FAIL %s mid_reset_outputs: ce=%b busy=%b done=%b rd_en=%b rd_addr=%0d pv=%b wv=%b wr_en=%b wr_addr=%0d tc=%0d, required all 0",
                   tag, bus.ce, bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.pix_valid,
                   bus.win_valid, bus.wr_en, bus.wr_addr, bus.total_cycles);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL %s after_reset_idle: wr_en=%b busy=%b, required 0 0",
                   tag, bus.wr_en, bus.busy);
        end
        rd_q.delete(); pix_q.delete(); win_q.delete(); wr_q.delete();
        finished = 1'b1;
        break;
      end

      exp_ce = (cy < done_cyc) && !stl;
      checks++;
      if (bus.ce !== exp_ce || bus.busy !== (cy < done_cyc) || bus.done !== (cy >= done_cyc)) begin
        errors++;
        $display("FAIL %s ctrl_c%0d: ce=%b busy=%b done=%b, required ce=%b busy=%b done=%b",
                 tag, cy, bus.ce, bus.busy, bus.done, exp_ce, cy < done_cyc, cy >= done_cyc);
      end

      if (bus.rd_en === 1'b1) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL %s rd_extra: rd_en at cycle %0d addr %0d, required none", tag, cy, bus.rd_addr);
        end else begin
          e = rd_q.pop_front();
          if (bus.rd_addr !== AW_T'(e.addr) || cy != e.cyc) begin
            errors++;
            $display("FAIL %s rd: addr %0d cycle %0d, required addr %0d cycle %0d",
                     tag, bus.rd_addr, cy, e.addr, e.cyc);
          end
        end
      end

      if (bus.pix_valid === 1'b1) begin
        checks++;
        if (pix_q.size() == 0) begin
          errors++;
          $display("FAIL %s pix_extra: pix_valid at cycle %0d, required none", tag, cy);
        end else begin
          e = pix_q.pop_front();
          if (cy != e.cyc) begin
            errors++;
            $display("FAIL %s pix: addr %0d seen cycle %0d, required cycle %0d", tag, e.addr, cy, e.cyc);
          end
        end
      end

      if (bus.win_valid === 1'b1) begin
        checks++;
        if (win_q.size() == 0) begin
          errors++;
          $display("FAIL %s win_extra: win_valid at cycle %0d, required none", tag, cy);
        end else begin
          e = win_q.pop_front();
          if (cy != e.cyc) begin
            errors++;
            $display("FAIL %s win: addr %0d seen cycle %0d, required cycle %0d", tag, e.addr, cy, e.cyc);
          end
        end
      end

      if (bus.wr_en === 1'b1) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL %s wr_extra: wr_en at cycle %0d wr_addr %0d, required none", tag, cy, bus.wr_addr);
        end else begin
          e = wr_q.pop_front();
          if (bus.wr_addr !== OW_T'(e.addr) || cy != e.cyc) begin
            errors++;
            $display("FAIL %s wr: wr_addr %0d cycle %0d, required wr_addr %0d cycle %0d",
                     tag, bus.wr_addr, cy, e.addr, e.cyc);
          end
        end
      end

      if (cy == done_cyc) begin
        checks++;
        if (bus.total_cycles !== 32'(exp_total(done_cyc))) begin
          errors++;
          $display("FAIL %s total_cycles: got %0d, required %0d", tag, bus.total_cycles, exp_total(done_cyc));
        end
        checks++;
        if (rd_q.size() != 0 || pix_q.size() != 0 || win_q.size() != 0 || wr_q.size() != 0) begin
          errors++;
          $display("FAIL %s missing_events: left rd=%0d pix=%0d win=%0d wr=%0d, required 0",
                   tag, rd_q.size(), pix_q.size(), win_q.size(), wr_q.size());
        end
        if (b2b) bus.start = 1'b1;
        finished = 1'b1;
        break;
      end
    end

    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles, required done at cycle %0d", tag, LIMIT, done_cyc);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.ce, bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.pix_valid,
         bus.win_valid, bus.wr_en, bus.wr_addr, bus.total_cycles} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b wr_en=%b tc=%0d, required all 0",
               bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.total_cycles);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b rd_en=%b, required 0 0 0",
               bus.busy, bus.done, bus.rd_en);
    end
  endtask

  task automatic test_basic();
    frame(1'b1, -10, 0, -1, -1, 1'b0, "basic");
    // done and the count hold in DONE with no start.
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.wr_en !== 1'b0 || bus.rd_en !== 1'b0 ||
        bus.total_cycles !== 32'(exp_total(STEPS))) begin
      errors++;
      $display("FAIL done_hold: done=%b busy=%b wr_en=%b rd_en=%b tc=%0d, required 1 0 0 0 %0d",
               bus.done, bus.busy, bus.wr_en, bus.rd_en, bus.total_cycles, exp_total(STEPS));
    end
  endtask

  task automatic test_stall();
    frame(1'b1, 7, 3, -1, -1, 1'b0, "stall");
  endtask

  task automatic test_start_ignored();
    frame(1'b1, -10, 0, 10, -1, 1'b0, "restart");
  endtask

  task automatic test_reset_mid();
    frame(1'b1, -10, 0, -1, 16, 1'b0, "rst16");
    frame(1'b1, -10, 0, -1, -1, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back();
    frame(1'b1, -10, 0, -1, -1, 1'b1, "b2b_first");
    frame(1'b0, -10, 0, -1, -1, 1'b0, "b2b_second");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame sequencer for the Sobel edge-detection datapath. On a start pulse it walks the input image memory in raster order and issues one read per cycle. It tracks the row and column of every pixel, flags the pixels whose 3x3 window is complete, and generates output-memory write strobes and addresses aligned to the datapath latency. It drains the pipeline, then reports done and the frame cycle count.

## Interface
Parameters:
- WIDTH, 240, image width in pixels (>=3)
- HEIGHT, 240, image height in pixels (>=3)
- RD_LAT, 1, input memory read latency in cycles (>=1)
- PIPE_LAT, 2, datapath latency from window-valid pixel to magnitude-valid, in cycles (>=1)
- Derived: TOTAL=WIDTH*HEIGHT; OUTTOT=(WIDTH-2)*(HEIGHT-2); AW=$clog2(TOTAL); OW=$clog2(OUTTOT)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle frame start request
- stall  in  1  hold request; freezes sequencing while high
- ce  out  1  datapath clock enable, equal to ~stall while busy, 0 otherwise
- busy  out  1  frame in progress (FETCH or DRAIN)
- done  out  1  frame complete, held until the next accepted start
- rd_en  out  1  input memory read strobe
- rd_addr  out  AW  input read address
- pix_valid  out  1  input memory data valid this cycle
- win_valid  out  1  the current valid pixel completes a 3x3 window
- wr_en  out  1  output memory write strobe
- wr_addr  out  OW  output write address
- total_cycles  out  32  frame cycle count

## Operation
- States: IDLE, FETCH, DRAIN, DONE. The reset state is IDLE. All outputs reset to 0.
- IDLE or DONE, start=1: move to FETCH. Clear rd_addr, row, col, wr_addr and total_cycles. Clear done.
- start is ignored while busy. It has no effect mid-frame.
- FETCH, stall=0:
  - rd_en=1 at rd_addr.
  - rd_addr increments.
  - col increments and wraps at WIDTH-1 to 0; row increments on that wrap.
  - After issuing rd_addr=TOTAL-1, move to DRAIN.
- FETCH, stall=1: rd_en=0. Address, row, col and all delay lines hold.
- pix_valid is rd_en delayed by RD_LAT ce-cycles. win_valid=pix_valid & (row>=2) & (col>=2), using the row and col of that delayed pixel.
- wr_en is win_valid delayed by PIPE_LAT ce-cycles. wr_addr increments after each wr_en and runs 0..OUTTOT-1. It never wraps within a frame.
- DRAIN counts RD_LAT+PIPE_LAT non-stalled cycles, then moves to DONE. Delay lines hold during stall.
- DONE: done=1, busy=0, rd_en/pix_valid/win_valid/wr_en=0.
- total_cycles increments every cycle spent in FETCH or DRAIN, stalled cycles included. It saturates at 2^32-1 and holds its value in DONE.
- rst_n low at any time: immediate return to IDLE. Outputs go to 0 and the partial frame is abandoned. No write strobes occur after reset is asserted.

## Timing
- Cycle 0 is the first FETCH cycle, i.e. the cycle after start is sampled.
- With no stall:
  - rd_en is high in cycles 0..TOTAL-1.
  - The pixel at address a is pix_valid in cycle a+RD_LAT.
  - That pixel's wr_en is in cycle a+RD_LAT+PIPE_LAT.
  - The last wr_en is in cycle TOTAL+RD_LAT+PIPE_LAT-1, the final DRAIN cycle.
  - done rises in cycle TOTAL+RD_LAT+PIPE_LAT.
  - total_cycles=TOTAL+RD_LAT+PIPE_LAT.
- Each stall cycle in FETCH or DRAIN delays all later events by exactly one cycle and adds 1 to total_cycles.
- start in DONE: done falls and FETCH begins in the next cycle. Back-to-back frames have one DONE cycle between them.

## Configuration
- SOBEL_CTRL_CYCLE_CNT_EN defined: the 32-bit total_cycles counter is built as described.
- SOBEL_CTRL_CYCLE_CNT_EN undefined: no counter is synthesized and total_cycles is tied to 0. All other behaviour is identical.

## Test plan
- WIDTH=5, HEIGHT=4, RD_LAT=1, PIPE_LAT=2, one start, no stall:
  - rd_addr 0..19, one per cycle.
  - win_valid exactly for addresses 12,13,14,17,18,19.
  - wr_en in cycles 15,16,17,20,21,22 with wr_addr 0..5.
  - done in cycle 23; total_cycles=23.
- Same configuration, stall high for 3 cycles starting in cycle 7 (FETCH):
  - wr_en sequence shifted by 3 cycles.
  - done in cycle 26; total_cycles=26.
  - ce=0 during the stall.
- start pulsed again in cycle 10 of a frame: ignored; results identical to the first case.
- rst_n asserted in cycle 16:
  - all outputs 0 immediately; state IDLE.
  - a new start then produces the full first-case sequence from wr_addr 0.
- Back-to-back: start in the first DONE cycle; the second frame repeats the first-case sequence with total_cycles=23.
- Build without SOBEL_CTRL_CYCLE_CNT_EN: total_cycles stays 0; all other first-case checks still pass.
